// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: ALUControl encodings
// matching the ALU decoder, and the arbiter FSM state encodings.
package alu_share_arbiter_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLL  = 4'b0010,
    ALU_SLT  = 4'b0011,
    ALU_SLTU = 4'b0100,
    ALU_XOR  = 4'b0101,
    ALU_SRA  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_OR   = 4'b1000,
    ALU_AND  = 4'b1001
  } alu_ctl_e;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// wrapping modulo NREQ; returns the winner as one-hot and as an index.
module alu_share_arbiter_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PTRW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PTRW-1:0] i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [PTRW-1:0] o_idx,
  output logic            o_any
);

  int              w_pos;
  logic [PTRW-1:0] w_pos_idx;

  // Walk from the farthest offset back to the pointer so the nearest hit wins.
  always_comb begin
    o_idx     = '0;
    o_any     = 1'b0;
    w_pos     = 0;
    w_pos_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_pos     = (int'(i_ptr) + k) % NREQ;
      w_pos_idx = PTRW'(w_pos);
      if (i_req[w_pos_idx]) begin
        o_idx = w_pos_idx;
        o_any = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign o_grant[gi] = o_any && (o_idx == PTRW'(gi));
    end
  endgenerate

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among NREQ requesters: round-robin grant,
// registered ALU operands, and a held response until the owner takes it.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int XLEN = 32,
  parameter int CTLW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      i_req_valid,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic [NREQ*XLEN-1:0] i_req_a,
  input  logic [NREQ*XLEN-1:0] i_req_b,
  input  logic [NREQ*CTLW-1:0] i_req_ctl,
  output logic [XLEN-1:0]      o_alu_a,
  output logic [XLEN-1:0]      o_alu_b,
  output logic [CTLW-1:0]      o_alu_ctl,
  input  logic [XLEN-1:0]      i_alu_result,
  input  logic                 i_alu_zero,
  output logic [NREQ-1:0]      o_rsp_valid,
  input  logic [NREQ-1:0]      i_rsp_ready,
  output logic [XLEN-1:0]      o_rsp_result,
  output logic                 o_rsp_zero,
  output logic                 o_busy
);

  localparam int PTRW = $clog2(NREQ);

  logic [1:0]      r_state;
  logic [PTRW-1:0] r_rr_ptr;
  logic [PTRW-1:0] r_owner;
  logic [XLEN-1:0] r_alu_a;
  logic [XLEN-1:0] r_alu_b;
  logic [CTLW-1:0] r_alu_ctl;
  logic [XLEN-1:0] r_rsp_result;
  logic            r_rsp_zero;
  logic [NREQ-1:0] r_rsp_valid;

  logic [NREQ-1:0] w_grant;
  logic [PTRW-1:0] w_idx;
  logic            w_any;
  logic            w_idle;
  logic            w_accept;
  logic            w_rsp_fire;
  logic [PTRW-1:0] w_ptr_next;
  logic [NREQ-1:0] w_owner_onehot;
  logic [XLEN-1:0] w_a_slice   [NREQ];
  logic [XLEN-1:0] w_b_slice   [NREQ];
  logic [CTLW-1:0] w_ctl_slice [NREQ];

  alu_share_arbiter_rr_arbiter #(
    .NREQ (NREQ),
    .PTRW (PTRW)
  ) u_rr_arbiter (
    .i_req   (i_req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slices
      assign w_a_slice[gi]      = i_req_a[gi*XLEN +: XLEN];
      assign w_b_slice[gi]      = i_req_b[gi*XLEN +: XLEN];
      assign w_ctl_slice[gi]    = i_req_ctl[gi*CTLW +: CTLW];
      assign w_owner_onehot[gi] = (r_owner == PTRW'(gi));
    end
  endgenerate

  assign w_idle     = (r_state == ST_IDLE);
  assign w_accept   = w_idle && w_any;
  // Only the owner's bit of r_rsp_valid is ever set, so other readies drop out.
  assign w_rsp_fire = |(i_rsp_ready & r_rsp_valid);
  assign w_ptr_next = (w_idx == PTRW'(NREQ - 1)) ? '0 : w_idx + 1'b1;

  // Grant is combinational but suppressed while reset is held.
  assign o_req_ready  = (rst_n && w_idle) ? w_grant : '0;
  assign o_alu_a      = r_alu_a;
  assign o_alu_b      = r_alu_b;
  assign o_alu_ctl    = r_alu_ctl;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_zero   = r_rsp_zero;
  assign o_busy       = !w_idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= '0;
      r_owner      <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_ctl    <= '0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_valid  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_alu_a   <= w_a_slice[w_idx];
            r_alu_b   <= w_b_slice[w_idx];
            r_alu_ctl <= w_ctl_slice[w_idx];
            r_owner   <= w_idx;
            r_rr_ptr  <= w_ptr_next;
            r_state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_result <= i_alu_result;
          r_rsp_zero   <= i_alu_zero;
          r_rsp_valid  <= w_owner_onehot;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (w_rsp_fire) begin
            r_rsp_valid <= '0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= '0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a behavioural ALU closes the loop,
// stimulus pushes hand-computed responses, a monitor pops and compares them.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int XLEN = 32;
  localparam int CTLW = 4;

  typedef struct {
    int              owner;
    logic [XLEN-1:0] res;
    logic            zero;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [XLEN-1:0]      a_arr   [NREQ];
  logic [XLEN-1:0]      b_arr   [NREQ];
  logic [CTLW-1:0]      ctl_arr [NREQ];
  logic [NREQ*XLEN-1:0] req_a_flat;
  logic [NREQ*XLEN-1:0] req_b_flat;
  logic [NREQ*CTLW-1:0] req_ctl_flat;
  logic [XLEN-1:0]      alu_a;
  logic [XLEN-1:0]      alu_b;
  logic [CTLW-1:0]      alu_ctl;
  logic [XLEN-1:0]      alu_result;
  logic                 alu_zero;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [XLEN-1:0]      rsp_result;
  logic                 rsp_zero;
  logic                 busy;

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t sb[$];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_pack
      assign req_a_flat[gi*XLEN +: XLEN]   = a_arr[gi];
      assign req_b_flat[gi*XLEN +: XLEN]   = b_arr[gi];
      assign req_ctl_flat[gi*CTLW +: CTLW] = ctl_arr[gi];
    end
  endgenerate

  alu_share_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .CTLW(CTLW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_a      (req_a_flat),
    .i_req_b      (req_b_flat),
    .i_req_ctl    (req_ctl_flat),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_ctl    (alu_ctl),
    .i_alu_result (alu_result),
    .i_alu_zero   (alu_zero),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_result (rsp_result),
    .o_rsp_zero   (rsp_zero),
    .o_busy       (busy)
  );

  // Behavioural ALU standing in for the real datapath ALU.
  always_comb begin
    case (alu_ctl)
      ALU_ADD:  alu_result = alu_a + alu_b;
      ALU_SUB:  alu_result = alu_a - alu_b;
      ALU_SLL:  alu_result = alu_a << alu_b[4:0];
      ALU_SLT:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_result = {31'd0, alu_a < alu_b};
      ALU_XOR:  alu_result = alu_a ^ alu_b;
      ALU_SRA:  alu_result = $signed(alu_a) >>> alu_b[4:0];
      ALU_SRL:  alu_result = alu_a >> alu_b[4:0];
      ALU_OR:   alu_result = alu_a | alu_b;
      ALU_AND:  alu_result = alu_a & alu_b;
      default:  alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int owner, input logic [XLEN-1:0] res, input logic zero);
    exp_t e;
    e.owner = owner;
    e.res   = res;
    e.zero  = zero;
    sb.push_back(e);
  endtask

  task automatic set_op(input int i, input logic [CTLW-1:0] ctl,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    ctl_arr[i] = ctl;
    a_arr[i]   = a;
    b_arr[i]   = b;
  endtask

  // Issue with mask, expect grant g, then run EXEC and RESP with the current rsp_ready.
  task automatic do_op(input string name, input logic [NREQ-1:0] mask, input int g,
                       input logic [XLEN-1:0] res, input logic zero);
    logic [NREQ-1:0] oh;
    oh        = NREQ'(1) << g;
    req_valid = mask;
    #1;
    chk(name, 64'(req_ready), 64'(oh));
    $display("issue %s: mask=%b grant=%b expect result=0x%0h zero=%0d", name, mask, req_ready, res, zero);
    push(g, res, zero);
    cyc();
    req_valid = '0;
    cyc();
    cyc();
  endtask

  // Monitor: pops an expectation at each response handshake, and checks
  // that a response left waiting does not change while it is held.
  logic            held = 1'b0;
  logic [XLEN-1:0] held_res;
  logic            held_zero;
  logic [NREQ-1:0] held_valid;

  always @(negedge clk) begin
    exp_t            e;
    logic [NREQ-1:0] oh;
    if (!rst_n) begin
      held = 1'b0;
    end else if (|rsp_valid) begin
      if (held) begin
        chk("mon_hold_result", 64'(rsp_result), 64'(held_res));
        chk("mon_hold_zero", 64'(rsp_zero), 64'(held_zero));
        chk("mon_hold_valid", 64'(rsp_valid), 64'(held_valid));
      end
      if (|(rsp_valid & rsp_ready)) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL mon_unexpected_rsp: got rsp_valid=%b result=0x%0h, expected no response",
                   rsp_valid, rsp_result);
        end else begin
          e  = sb.pop_front();
          oh = NREQ'(1) << e.owner;
          $display("rsp: valid=%b result=0x%0h zero=%0d (expect owner %0d result=0x%0h zero=%0d)",
                   rsp_valid, rsp_result, rsp_zero, e.owner, e.res, e.zero);
          chk("mon_owner", 64'(rsp_valid), 64'(oh));
          chk("mon_result", 64'(rsp_result), 64'(e.res));
          chk("mon_zero", 64'(rsp_zero), 64'(e.zero));
        end
        held = 1'b0;
      end else begin
        held       = 1'b1;
        held_res   = rsp_result;
        held_zero  = rsp_zero;
        held_valid = rsp_valid;
      end
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000, expected to finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [5];
    logic [NREQ-1:0] oh;
    order = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    rsp_ready = '0;
    for (int i = 0; i < NREQ; i++) set_op(i, 4'd0, '0, '0);

    // Reset: outputs cleared and req_ready gated even with a valid request.
    set_op(0, ALU_ADD, 32'd5, 32'd7);
    req_valid = 4'b0001;
    cyc();
    cyc();
    chk("rst_req_ready", 64'(req_ready), 64'(4'b0000));
    chk("rst_busy", 64'(busy), 64'(1'b0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(4'b0000));
    chk("rst_alu_a", 64'(alu_a), 64'(32'd0));
    chk("rst_alu_b", 64'(alu_b), 64'(32'd0));
    chk("rst_alu_ctl", 64'(alu_ctl), 64'(4'd0));
    chk("rst_rsp_result", 64'(rsp_result), 64'(32'd0));
    chk("rst_rsp_zero", 64'(rsp_zero), 64'(1'b0));
    req_valid = '0;
    rsp_ready = 4'b0001;
    rst_n = 1'b1;
    cyc();

    // Test 1: single ADD from req0, exact latency.
    req_valid = 4'b0001;
    #1;
    chk("t1_req_ready", 64'(req_ready), 64'(4'b0001));
    $display("issue t1: req0 ADD 5+7 grant=%b", req_ready);
    push(0, 32'd12, 1'b0);
    cyc();
    req_valid = '0;
    chk("t1_exec_busy", 64'(busy), 64'(1'b1));
    chk("t1_exec_ready", 64'(req_ready), 64'(4'b0000));
    chk("t1_alu_a", 64'(alu_a), 64'(32'd5));
    chk("t1_alu_b", 64'(alu_b), 64'(32'd7));
    chk("t1_alu_ctl", 64'(alu_ctl), 64'(ALU_ADD));
    chk("t1_exec_rsp_valid", 64'(rsp_valid), 64'(4'b0000));
    cyc();
    chk("t1_rsp_valid", 64'(rsp_valid), 64'(4'b0001));
    chk("t1_rsp_result", 64'(rsp_result), 64'(32'd12));
    chk("t1_rsp_zero", 64'(rsp_zero), 64'(1'b0));
    cyc();
    chk("t1_idle_busy", 64'(busy), 64'(1'b0));

    // Test 2: all four valid from a fresh pointer; order 0,1,2,3,0, 3-cycle issue.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    set_op(0, ALU_ADD, 32'd10, 32'd20);
    set_op(1, ALU_SUB, 32'd100, 32'd1);
    set_op(2, ALU_XOR, 32'h0000_F0F0, 32'h0000_0FF0);
    set_op(3, ALU_SLL, 32'd1, 32'd4);
    rsp_ready = 4'b1111;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      oh = NREQ'(1) << order[k];
      chk("t2_grant", 64'(req_ready), 64'(oh));
      $display("issue t2[%0d]: grant=%b", k, req_ready);
      case (order[k])
        0: push(0, 32'd30, 1'b0);
        1: push(1, 32'd99, 1'b0);
        2: push(2, 32'h0000_FF00, 1'b0);
        default: push(3, 32'd16, 1'b0);
      endcase
      cyc();
      chk("t2_exec_ready", 64'(req_ready), 64'(4'b0000));
      cyc();
      chk("t2_resp_ready", 64'(req_ready), 64'(4'b0000));
      cyc();
      if (k == 4) req_valid = '0;
    end

    // Test 3: SUB 3-3 held for 5 cycles with rsp_ready low; pointer is 1.
    rsp_ready = '0;
    set_op(1, ALU_SUB, 32'd3, 32'd3);
    req_valid = 4'b0010;
    #1;
    chk("t3_grant", 64'(req_ready), 64'(4'b0010));
    $display("issue t3: req1 SUB 3-3 grant=%b", req_ready);
    push(1, 32'd0, 1'b1);
    cyc();
    req_valid = 4'b0101;
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", 64'(rsp_valid), 64'(4'b0010));
      chk("t3_hold_result", 64'(rsp_result), 64'(32'd0));
      chk("t3_hold_zero", 64'(rsp_zero), 64'(1'b1));
      chk("t3_hold_ready", 64'(req_ready), 64'(4'b0000));
      cyc();
    end
    req_valid = '0;
    rsp_ready = 4'b0010;
    cyc();
    chk("t3_idle_busy", 64'(busy), 64'(1'b0));
    chk("t3_idle_rsp_valid", 64'(rsp_valid), 64'(4'b0000));
    chk("t3_alu_a_kept", 64'(alu_a), 64'(32'd3));

    // Test 4: pointer 2 -> grant 2 (ptr 3); only req2 again wraps to 2; then ptr 3 favours req3.
    rsp_ready = 4'b1111;
    set_op(2, ALU_AND, 32'h0000_00FF, 32'h0000_000F);
    do_op("t4_grant2_first", 4'b0100, 2, 32'h0000_000F, 1'b0);
    set_op(2, ALU_SRA, 32'h8000_0000, 32'd4);
    do_op("t4_grant2_wrap", 4'b0100, 2, 32'hF800_0000, 1'b0);
    set_op(3, ALU_SLTU, 32'd1, 32'd2);
    do_op("t4_grant3_ptr3", 4'b1001, 3, 32'd1, 1'b0);

    // Test 5: reset while req1 is in EXEC; op is dropped, pointer back to 0.
    set_op(1, ALU_XOR, 32'h1234_5678, 32'h0000_0001);
    req_valid = 4'b0010;
    #1;
    chk("t5_grant1", 64'(req_ready), 64'(4'b0010));
    cyc();
    req_valid = 4'b0011;
    chk("t5_exec_busy", 64'(busy), 64'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("t5_rst_alu_a", 64'(alu_a), 64'(32'd0));
    chk("t5_rst_alu_b", 64'(alu_b), 64'(32'd0));
    chk("t5_rst_alu_ctl", 64'(alu_ctl), 64'(4'd0));
    chk("t5_rst_rsp_valid", 64'(rsp_valid), 64'(4'b0000));
    chk("t5_rst_rsp_result", 64'(rsp_result), 64'(32'd0));
    chk("t5_rst_busy", 64'(busy), 64'(1'b0));
    chk("t5_rst_req_ready", 64'(req_ready), 64'(4'b0000));
    cyc();
    cyc();
    set_op(0, ALU_OR, 32'h0000_00A0, 32'h0000_000B);
    rst_n = 1'b1;
    #1;
    chk("t5_grant0", 64'(req_ready), 64'(4'b0001));
    $display("issue t5: after reset grant=%b", req_ready);
    push(0, 32'h0000_00AB, 1'b0);
    cyc();
    req_valid = '0;
    chk("t5_no_stale", 64'(rsp_valid), 64'(4'b0000));
    cyc();
    cyc();

    // Test 6: only non-owners ready keeps RESP; owner ready releases it.
    rsp_ready = 4'b1101;
    set_op(1, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    req_valid = 4'b0010;
    #1;
    chk("t6_grant", 64'(req_ready), 64'(4'b0010));
    $display("issue t6: req1 SLT -1<1 grant=%b", req_ready);
    push(1, 32'd1, 1'b0);
    cyc();
    req_valid = '0;
    cyc();
    chk("t6_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
    cyc();
    chk("t6_held_busy", 64'(busy), 64'(1'b1));
    chk("t6_held_valid", 64'(rsp_valid), 64'(4'b0010));
    cyc();
    chk("t6_held_valid2", 64'(rsp_valid), 64'(4'b0010));
    rsp_ready = 4'b0010;
    cyc();
    chk("t6_idle_busy", 64'(busy), 64'(1'b0));
    chk("t6_idle_rsp_valid", 64'(rsp_valid), 64'(4'b0000));

    cyc();
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
